// File: rtl/qspi_xfer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qspi_xfer_if : memory-bus request/response and QSPI pad signals of qspi_xfer
// Revision 1.0
// ---------------------------------------------------------------------------
interface qspi_xfer_if #(
  parameter int ADR_W = 22
);
  logic             sel_rom_ram_i;
  logic             stb_i;
  logic             we_i;
  logic [3:0]       be_i;
  logic [ADR_W-1:0] adr_i;
  logic [31:0]      dat_i;
  logic             ack_o;
  logic [31:0]      dat_o;
  logic             cs_ram_on;
  logic             cs_rom_on;
  logic             sck_o;
  logic [3:0]       sd_i;
  logic [3:0]       sd_o;
  logic [3:0]       sd_oen_o;

  // Master is the bus decoder plus the pad/flash side; slave is the engine.
  modport master (
    output sel_rom_ram_i, stb_i, we_i, be_i, adr_i, dat_i, sd_i,
    input  ack_o, dat_o, cs_ram_on, cs_rom_on, sck_o, sd_o, sd_oen_o
  );

  modport slave (
    input  sel_rom_ram_i, stb_i, we_i, be_i, adr_i, dat_i, sd_i,
    output ack_o, dat_o, cs_ram_on, cs_rom_on, sck_o, sd_o, sd_oen_o
  );
endinterface
`default_nettype wire

// File: rtl/qspi_xfer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qspi_xfer : QPI transaction engine, one word read/write to external ROM/RAM
// Revision 1.0
// ---------------------------------------------------------------------------
module qspi_xfer #(
  parameter int         ADR_W  = 22,
  parameter int         DUMMY  = 4,
  parameter logic [7:0] CMD_RD = 8'hEB,
  parameter logic [7:0] CMD_WR = 8'h38
) (
  input  wire logic  clk_i,
  input  wire logic  rst_i,
  qspi_xfer_if.slave bus
);
  localparam int MAX_SLOTS = (DUMMY > 8) ? DUMMY : 8;
  localparam int CNT_W     = $clog2(MAX_SLOTS);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_DUMMY = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;
  localparam logic [2:0] ST_WDATA = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  logic [2:0]       r_state;
  logic             r_ph;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sel;
  logic             r_we;
  logic [1:0]       r_start;
  logic [2:0]       r_nbytes;
  logic [ADR_W-1:0] r_adr;
  logic [31:0]      r_wdat;
  logic [27:0]      r_rx;
  logic [31:0]      r_dat;

  logic [1:0]       w_lo;
  logic [1:0]       w_hi;
  logic [2:0]       w_nb;
  logic             w_degen;
  logic [CNT_W-1:0] w_last;
  logic [2:0]       w_next;
  logic [31:0]      w_rx_next;
  logic             w_active;
  logic [7:0]       w_cmd;
  logic [23:0]      w_addr24;
  logic [3:0]       w_sd;

  // Byte-enable span: writes cover lowest..highest set byte.
  always_comb begin
    w_lo = 2'd0;
    w_hi = 2'd0;
    for (int i = 3; i >= 0; i--) if (bus.be_i[i]) w_lo = 2'(i);
    for (int i = 0; i < 4; i++)  if (bus.be_i[i]) w_hi = 2'(i);
  end

  assign w_nb      = {1'b0, w_hi} - {1'b0, w_lo} + 3'd1;
  assign w_degen   = bus.we_i && (bus.sel_rom_ram_i || (bus.be_i == 4'd0));
  assign w_rx_next = {r_rx, bus.sd_i};

  always_comb begin
    w_last = '0;
    w_next = ST_IDLE;
    case (r_state)
      ST_CMD: begin
        w_last = CNT_W'(1);
        w_next = ST_ADDR;
      end
      ST_ADDR: begin
        w_last = CNT_W'(5);
        if (r_we)            w_next = ST_WDATA;
        else if (DUMMY > 0)  w_next = ST_DUMMY;
        else                 w_next = ST_RDATA;
      end
      ST_DUMMY: begin
        w_last = CNT_W'(DUMMY - 1);
        w_next = ST_RDATA;
      end
      ST_RDATA: begin
        w_last = CNT_W'(7);
        w_next = ST_DONE;
      end
      ST_WDATA: begin
        w_last = CNT_W'({r_nbytes, 1'b0} - 4'd1);
        w_next = ST_DONE;
      end
      default: begin
        w_last = '0;
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_ph     <= 1'b0;
      r_cnt    <= '0;
      r_sel    <= 1'b0;
      r_we     <= 1'b0;
      r_start  <= 2'd0;
      r_nbytes <= 3'd0;
      r_adr    <= '0;
      r_wdat   <= 32'd0;
      r_rx     <= 28'd0;
      r_dat    <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ph  <= 1'b0;
          r_cnt <= '0;
          if (bus.stb_i) begin
            r_sel    <= bus.sel_rom_ram_i;
            r_we     <= bus.we_i;
            r_adr    <= bus.adr_i;
            r_start  <= bus.we_i ? w_lo : 2'd0;
            r_nbytes <= w_nb;
            // Pre-align so the first byte to send sits in [7:0].
            r_wdat   <= bus.dat_i >> {w_lo, 3'b000};
            r_state  <= w_degen ? ST_DONE : ST_CMD;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_ph <= ~r_ph;
          if (r_ph) begin
            if (r_state == ST_RDATA) r_rx <= w_rx_next[27:0];
            if (r_cnt == w_last) begin
              r_cnt   <= '0;
              r_state <= w_next;
              if (r_state == ST_RDATA)
                r_dat <= {w_rx_next[7:0], w_rx_next[15:8],
                          w_rx_next[23:16], w_rx_next[31:24]};
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign w_active = (r_state == ST_CMD)   || (r_state == ST_ADDR) ||
                    (r_state == ST_DUMMY) || (r_state == ST_RDATA) ||
                    (r_state == ST_WDATA);
  assign w_cmd    = r_we ? CMD_WR : CMD_RD;
  assign w_addr24 = 24'({r_adr, r_start});

  always_comb begin
    w_sd = 4'd0;
    case (r_state)
      ST_CMD:   w_sd = r_cnt[0] ? w_cmd[3:0] : w_cmd[7:4];
      ST_ADDR:  w_sd = 4'(w_addr24 >> (5'd20 - {r_cnt[2:0], 2'b00}));
      ST_WDATA: w_sd = 4'(r_wdat >> ({r_cnt[2:1], 3'b000} + (r_cnt[0] ? 5'd0 : 5'd4)));
      default:  w_sd = 4'd0;
    endcase
  end

  assign bus.sd_o      = w_sd;
  assign bus.sck_o     = w_active & r_ph;
  assign bus.cs_rom_on = ~(w_active & r_sel);
  assign bus.cs_ram_on = ~(w_active & ~r_sel);
  assign bus.sd_oen_o  = ((r_state == ST_CMD) || (r_state == ST_ADDR) ||
                          (r_state == ST_WDATA)) ? 4'h0 : 4'hF;
  assign bus.ack_o     = (r_state == ST_DONE);
  assign bus.dat_o     = r_dat;
endmodule
`default_nettype wire

// File: tb/tb_qspi_xfer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_qspi_xfer : directed bench for qspi_xfer with a small QPI device model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_qspi_xfer;
  localparam int DUMMY = 4;

  logic clk;
  logic rst;

  qspi_xfer_if #(.ADR_W(22)) bus ();

  qspi_xfer #(
    .ADR_W (22),
    .DUMMY (DUMMY),
    .CMD_RD(8'hEB),
    .CMD_WR(8'h38)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          sck_cnt = 0;
  int          rom_low = 0;
  int          ram_low = 0;
  int          f_slots = 0;
  int          tx_n = 0;
  logic [63:0] tx_bits = 64'd0;
  bit          prev_low = 1'b0;
  logic [3:0]  rd_nibs [8];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_nibs(input logic [3:0] base);
    for (int i = 0; i < 8; i++) rd_nibs[i] = base + 4'(i);
  endtask

  // Device model: logs driven nibbles per transaction and serves read data.
  always @(negedge clk) begin
    if (bus.cs_rom_on && bus.cs_ram_on) begin
      bus.sd_i = 4'd0;
    end else begin
      if (!prev_low) begin
        tx_bits = 64'd0;
        tx_n    = 0;
        f_slots = 0;
      end
      if (bus.sck_o) begin
        sck_cnt++;
        if (bus.sd_oen_o == 4'h0) begin
          tx_bits = {tx_bits[59:0], bus.sd_o};
          tx_n++;
        end else begin
          f_slots++;
        end
      end else if (bus.sd_oen_o == 4'hF && f_slots >= DUMMY && f_slots < DUMMY + 8) begin
        bus.sd_i = rd_nibs[f_slots - DUMMY];
      end
    end
    if (!bus.cs_rom_on) rom_low++;
    if (!bus.cs_ram_on) ram_low++;
    prev_low = !(bus.cs_rom_on && bus.cs_ram_on);
  end

  task automatic do_xfer(input logic sel, input logic we, input logic [3:0] be,
                         input logic [21:0] adr, input logic [31:0] dat,
                         input bit cont, input bit hold, input int drop_at,
                         output int lat, output int csc, output int d_sck,
                         output int d_rom, output int d_ram);
    int s_sck, s_rom, s_ram;
    if (!cont) @(negedge clk);
    bus.sel_rom_ram_i = sel;
    bus.we_i          = we;
    bus.be_i          = be;
    bus.adr_i         = adr;
    bus.dat_i         = dat;
    bus.stb_i         = 1'b1;
    s_sck = sck_cnt;
    s_rom = rom_low;
    s_ram = ram_low;
    lat = 0;
    csc = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (csc == 0 && !(bus.cs_rom_on && bus.cs_ram_on)) csc = c;
      if (c == drop_at) bus.stb_i = 1'b0;
      if (bus.ack_o) begin
        lat = c;
        break;
      end
    end
    check_val("ack_seen", 64'(lat != 0), 64'd1);
    if (!hold) bus.stb_i = 1'b0;
    d_sck = sck_cnt - s_sck;
    d_rom = rom_low - s_rom;
    d_ram = ram_low - s_ram;
  endtask

  int lat, csc, d_sck, d_rom, d_ram;

  initial begin
    rst = 1'b1;
    bus.sel_rom_ram_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    bus.be_i  = 4'h0;
    bus.adr_i = 22'd0;
    bus.dat_i = 32'd0;
    set_nibs(4'h1);

    repeat (2) @(negedge clk);
    check_val("rst_cs_ram", 64'(bus.cs_ram_on), 64'd1);
    check_val("rst_cs_rom", 64'(bus.cs_rom_on), 64'd1);
    check_val("rst_sck", 64'(bus.sck_o), 64'd0);
    check_val("rst_sd", 64'(bus.sd_o), 64'd0);
    check_val("rst_oen", 64'(bus.sd_oen_o), 64'hF);
    check_val("rst_ack", 64'(bus.ack_o), 64'd0);
    check_val("rst_dat", 64'(bus.dat_o), 64'd0);
    rst = 1'b0;

    // ROM read
    do_xfer(1'b1, 1'b0, 4'h0, 22'h000001, 32'd0, 1'b0, 1'b0, 0, lat, csc, d_sck, d_rom, d_ram);
    check_val("rd_lat", 64'(lat), 64'd41);
    check_val("rd_dat", 64'(bus.dat_o), 64'h78563412);
    check_val("rd_tx_n", 64'(tx_n), 64'd8);
    check_val("rd_tx", tx_bits, 64'hEB000004);
    check_val("rd_fslots", 64'(f_slots), 64'd12);
    check_val("rd_sck", 64'(d_sck), 64'd20);
    check_val("rd_rom_low", 64'(d_rom), 64'd40);
    check_val("rd_ram_low", 64'(d_ram), 64'd0);

    // RAM word write
    do_xfer(1'b0, 1'b1, 4'hF, 22'h000010, 32'hDEADBEEF, 1'b0, 1'b0, 0, lat, csc, d_sck, d_rom, d_ram);
    check_val("ww_lat", 64'(lat), 64'd33);
    check_val("ww_tx_n", 64'(tx_n), 64'd16);
    check_val("ww_tx", tx_bits, 64'h38000040EFBEADDE);
    check_val("ww_sck", 64'(d_sck), 64'd16);
    check_val("ww_rom_low", 64'(d_rom), 64'd0);
    check_val("ww_ram_low", 64'(d_ram), 64'd32);
    check_val("ww_dat_hold", 64'(bus.dat_o), 64'h78563412);

    // RAM byte write, byte 2
    do_xfer(1'b0, 1'b1, 4'b0100, 22'h000003, 32'h00AB0000, 1'b0, 1'b0, 0, lat, csc, d_sck, d_rom, d_ram);
    check_val("bw_lat", 64'(lat), 64'd21);
    check_val("bw_tx_n", 64'(tx_n), 64'd10);
    check_val("bw_tx", tx_bits, 64'h3800000EAB);

    // RAM upper halfword write
    do_xfer(1'b0, 1'b1, 4'b1100, 22'h000005, 32'hCAFE0000, 1'b0, 1'b0, 0, lat, csc, d_sck, d_rom, d_ram);
    check_val("hw_lat", 64'(lat), 64'd25);
    check_val("hw_tx_n", 64'(tx_n), 64'd12);
    check_val("hw_tx", tx_bits, 64'h38000016FECA);

    // Degenerate: ROM write
    do_xfer(1'b1, 1'b1, 4'hF, 22'h000007, 32'h11223344, 1'b0, 1'b0, 0, lat, csc, d_sck, d_rom, d_ram);
    check_val("romw_lat", 64'(lat), 64'd1);
    check_val("romw_sck", 64'(d_sck), 64'd0);
    check_val("romw_cs", 64'(d_rom + d_ram), 64'd0);
    check_val("romw_dat", 64'(bus.dat_o), 64'h78563412);

    // Degenerate: RAM write with no byte enables
    do_xfer(1'b0, 1'b1, 4'h0, 22'h000008, 32'h55667788, 1'b0, 1'b0, 0, lat, csc, d_sck, d_rom, d_ram);
    check_val("be0_lat", 64'(lat), 64'd1);
    check_val("be0_sck", 64'(d_sck), 64'd0);
    check_val("be0_cs", 64'(d_rom + d_ram), 64'd0);
    check_val("be0_dat", 64'(bus.dat_o), 64'h78563412);

    // Reset asserted during ADDR of a read
    @(negedge clk);
    bus.sel_rom_ram_i = 1'b1;
    bus.we_i  = 1'b0;
    bus.adr_i = 22'h000009;
    bus.stb_i = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("mrst_cs_rom", 64'(bus.cs_rom_on), 64'd1);
    check_val("mrst_cs_ram", 64'(bus.cs_ram_on), 64'd1);
    check_val("mrst_sck", 64'(bus.sck_o), 64'd0);
    check_val("mrst_oen", 64'(bus.sd_oen_o), 64'hF);
    check_val("mrst_ack", 64'(bus.ack_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.stb_i = 1'b0;
    set_nibs(4'h9);
    do_xfer(1'b1, 1'b0, 4'h0, 22'h2AAAAA, 32'd0, 1'b0, 1'b0, 0, lat, csc, d_sck, d_rom, d_ram);
    check_val("post_rst_lat", 64'(lat), 64'd41);
    check_val("post_rst_tx", tx_bits, 64'hEBAAAAA8);
    check_val("post_rst_dat", 64'(bus.dat_o), 64'hF0DEBC9A);

    // Back-to-back reads with stb held high
    set_nibs(4'h1);
    do_xfer(1'b1, 1'b0, 4'h0, 22'h000002, 32'd0, 1'b0, 1'b1, 0, lat, csc, d_sck, d_rom, d_ram);
    check_val("b2b1_lat", 64'(lat), 64'd41);
    check_val("b2b1_dat", 64'(bus.dat_o), 64'h78563412);
    set_nibs(4'h9);
    do_xfer(1'b1, 1'b0, 4'h0, 22'h000002, 32'd0, 1'b1, 1'b0, 0, lat, csc, d_sck, d_rom, d_ram);
    check_val("b2b2_cs_gap", 64'(csc), 64'd2);
    check_val("b2b2_lat", 64'(lat), 64'd42);
    check_val("b2b2_dat", 64'(bus.dat_o), 64'hF0DEBC9A);

    // Read with stb dropped early
    set_nibs(4'h1);
    do_xfer(1'b1, 1'b0, 4'h0, 22'h000001, 32'd0, 1'b0, 1'b0, 5, lat, csc, d_sck, d_rom, d_ram);
    check_val("drop_lat", 64'(lat), 64'd41);
    check_val("drop_dat", 64'(bus.dat_o), 64'h78563412);
    repeat (3) @(negedge clk);
    check_val("drop_idle_cs", 64'(bus.cs_rom_on & bus.cs_ram_on), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/qspi_xfer.md
Name: qspi_xfer

Overview:
- QSPI transaction engine serving the SoC memory bus for external ROM and RAM.
- Accepts one word-addressed read or write from the memory-bus decoder and serialises it onto 4 shared data lanes with separate ROM and RAM chip selects.
- Returns read data and a single-cycle ack.
- Both devices run in QPI mode, so command, address and data all travel 4 bits per SCK.

Parameters:
ADR_W, 22, word-address width; byte address on the wire is {adr, 2'b00} zero-extended to 24 bits
DUMMY, 4, dummy nibble slots between address and read data
CMD_RD, 8'hEB, quad read command
CMD_WR, 8'h38, quad write command (RAM only)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
sel_rom_ram_i  in  1  1 = ROM, 0 = RAM
stb_i  in  1  request strobe; held until ack_o
we_i  in  1  write enable
be_i  in  4  byte enables (writes only)
adr_i  in  ADR_W  word address
dat_i  in  32  write data; byte0 = [7:0]
ack_o  out  1  one-cycle completion pulse
dat_o  out  32  read data
cs_ram_on  out  1  RAM chip select, active-low
cs_rom_on  out  1  ROM chip select, active-low
sck_o  out  1  SPI clock, idle low
sd_i  in  4  lane inputs
sd_o  out  4  lane outputs
sd_oen_o  out  4  lane output-disable; 1 = tri-state

Behaviour:
- Reset (async, any state): state=IDLE; cs_ram_on=1, cs_rom_on=1, sck_o=0, sd_o=0, sd_oen_o=4'hF, ack_o=0, dat_o=0.
- Accept: request taken only in IDLE with stb_i=1. sel, we, be, adr and dat are latched in that cycle. Input changes after that, including stb_i dropping, are ignored; the transfer completes and ack_o still pulses.
- States: IDLE -> CMD(2 slots) -> ADDR(6 slots) -> [read: DUMMY(DUMMY slots) -> RDATA(8 slots)] | [write: WDATA(2*nbytes slots)] -> DONE -> IDLE.
- Nibble slot = 2 clk_i cycles:
  - Phase A: sck_o=0, sd_o holds the nibble.
  - Phase B: sck_o=1.
  - Reads: sd_i is sampled at the clock edge ending phase B.
- Bit order: MSB nibble first for command and address. Data is sent byte0 first, high nibble first within each byte.
- Chip select:
  - The selected cs goes low on entry to CMD and stays low through the last slot.
  - Both cs are high in DONE and IDLE, giving a minimum of 2 cs-high cycles between transfers (DONE + accepting IDLE).
- Lane direction:
  - sd_oen_o=0 during CMD, ADDR and WDATA.
  - sd_oen_o=4'hF during DUMMY, RDATA, DONE and IDLE.
- Read:
  - Always a full word; be_i is ignored.
  - dat_o is assembled little-endian and updated in the DONE cycle; ack_o=1 in DONE.
  - dat_o holds its value until the next read completes.
- Write to RAM:
  - Start byte s = lowest set bit of be; nbytes = popcount(be).
  - Wire address = {adr, s[1:0]}.
  - Bytes s..s+nbytes-1 of dat are sent in that order.
  - The bus guarantees contiguous be (1111, 0011, 1100, 0001, 0010, 0100, 1000). Non-contiguous be writes span lowest..highest set byte.
- Degenerate writes: a write with sel_rom_ram_i=1 (ROM), or with be=0, performs no bus activity. The engine goes directly IDLE -> DONE, ack_o pulses on the next cycle, and dat_o is unchanged.
- Latency, stb accept edge to ack cycle:
  - Read: 2*(16+DUMMY)+1, i.e. 41 at DUMMY=4.
  - Word write: 33. Halfword write: 25. Byte write: 21. Degenerate write: 1.
- Back-to-back: after DONE, an IDLE cycle seeing stb_i=1 accepts a new request. Maximum throughput is one request per latency+1 cycles.
- Counters: slot counter sized for max(8, DUMMY, 8) slots; it resets on each state entry with no wrap.

Test Plan:
- ROM read, adr=22'h000001, model returns nibbles 1,2,3,4,5,6,7,8 -> cmd EB then address 000004 on lanes; oen=F during 4 dummy slots; dat_o=32'h78563412; ack at cycle 41; cs_ram_on stays 1.
- RAM word write, adr=22'h000010, dat=32'hDEADBEEF, be=1111 -> cmd 38, address 000040, nibbles E,F,B,E,A,D,D,E; ack at cycle 33; cs_rom_on stays 1.
- RAM byte write, be=0100, dat=32'h00AB0000, adr=22'h3 -> address 00000E, nibbles A,B; ack at cycle 21.
- ROM write (sel=1, we=1) and RAM write with be=0 -> no cs low and no sck toggle; ack one cycle after accept; dat_o unchanged.
- Assert rst_i during ADDR of a read -> in the same cycle both cs=1, sck=0, oen=F, ack=0; a fresh read after release completes normally.
- Two reads back-to-back with stb_i held high, and a read with stb_i dropped at cycle 5 -> second accept exactly 2 cycles after the first cs rises; dropped-stb read still completes and acks.
